keypad_entry: RTL and testbench

- Parametrised successor to the single-cursor hex entry block.
- Converts debounced push-button rising edges into an NDIG-digit hex value for the seven-segment display path.
- Supports two entry modes: overwrite-at-cursor with cursor movement, and calculator-style shift-in.
- Also supports backspace, clear, multi-key rejection and event/error pulses.
- Sits between the button synchroniser/debouncer and the display/ALU consumers.

---
 rtl/keypad_entry.sv | 188 ++++++++++++++++++
 tb/tb_keypad_entry.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: turns debounced push-button rising edges into an NDIG-digit
// hex value, with overwrite-at-cursor and calculator-style shift-in modes,
// plus backspace, clear, multi-key rejection and event/error pulses.
module keypad_entry #(
    parameter int NDIG     = 8,
    parameter int AUTO_ADV = 1,
    parameter int WRAP     = 1,
    localparam int CW      = $clog2(NDIG),
    localparam int CNW     = $clog2(NDIG + 1)
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic [15:0]       pb,
    input  logic              cur_left,
    input  logic              cur_right,
    input  logic              bksp,
    input  logic              clr,
    input  logic              mode,
    output logic [NDIG*4-1:0] digits,
    output logic [NDIG-1:0]   flt_pt,
    output logic [CW-1:0]     cursor,
    output logic [CNW-1:0]    count,
    output logic              full,
    output logic              key_evt,
    output logic              err
);

    localparam logic [CW-1:0]  LAST_POS  = CW'(NDIG - 1);
    localparam logic [CNW-1:0] MAX_COUNT = CNW'(NDIG);

    // Edge-detect history registers
    logic [15:0] r_pb_q;
    logic        r_left_q;
    logic        r_right_q;
    logic        r_bksp_q;
    logic        r_clr_q;
    logic        r_mode_q;

    // Architectural state and registered outputs
    logic [NDIG*4-1:0] r_digits;
    logic [NDIG-1:0]   r_flt_pt;
    logic [CW-1:0]     r_cursor;
    logic [CNW-1:0]    r_count;
    logic              r_full;
    logic              r_key_evt;
    logic              r_err;

    // Rising edges and decoded key
    logic [15:0] w_pb_rise;
    logic        w_left_rise;
    logic        w_right_rise;
    logic        w_bksp_rise;
    logic        w_clr_rise;
    logic        w_mode_change;
    logic        w_pb_any;
    logic        w_pb_onehot;
    logic [3:0]  w_value;

    // Next-state values
    logic [NDIG*4-1:0] w_digits_next;
    logic [NDIG-1:0]   w_flt_pt_next;
    logic [CW-1:0]     w_cursor_next;
    logic [CNW-1:0]    w_count_next;
    logic              w_full_next;
    logic              w_key_evt_next;
    logic              w_err_next;

    // Cursor step toward the left (higher index), wrapping or saturating at the top
    function automatic logic [CW-1:0] cursorInc(input logic [CW-1:0] c);
        if (c == LAST_POS) begin
            return (WRAP != 0) ? '0 : LAST_POS;
        end
        return c + CW'(1);
    endfunction

    // Cursor step toward the right (lower index), wrapping or saturating at zero
    function automatic logic [CW-1:0] cursorDec(input logic [CW-1:0] c);
        if (c == '0) begin
            return (WRAP != 0) ? LAST_POS : '0;
        end
        return c - CW'(1);
    endfunction

    // Rising-edge extraction and key decode; a single rising bit is a valid key
    always_comb begin
        w_pb_rise     = pb & ~r_pb_q;
        w_left_rise   = cur_left & ~r_left_q;
        w_right_rise  = cur_right & ~r_right_q;
        w_bksp_rise   = bksp & ~r_bksp_q;
        w_clr_rise    = clr & ~r_clr_q;
        w_mode_change = mode != r_mode_q;
        w_pb_any      = |w_pb_rise;
        w_pb_onehot   = w_pb_any && ((w_pb_rise & (w_pb_rise - 16'd1)) == 16'd0);
        w_value       = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (w_pb_rise[k]) begin
                w_value = 4'(k);
            end
        end
    end

    // One action per cycle, in priority order: mode change, clear, backspace, digit, cursor move
    always_comb begin
        w_digits_next  = r_digits;
        w_cursor_next  = r_cursor;
        w_count_next   = r_count;
        w_key_evt_next = 1'b0;
        w_err_next     = 1'b0;

        if (w_mode_change || w_clr_rise) begin
            w_digits_next = '0;
            w_cursor_next = '0;
            w_count_next  = '0;
        end else if (w_bksp_rise) begin
            if (r_mode_q) begin
                w_digits_next = {4'h0, r_digits[NDIG*4-1:4]};
                if (r_count != '0) begin
                    w_count_next = r_count - CNW'(1);
                end
            end else begin
                w_digits_next[int'(r_cursor)*4 +: 4] = 4'h0;
            end
        end else if (w_pb_any) begin
            if (!w_pb_onehot) begin
                w_err_next = 1'b1;
            end else if (r_mode_q) begin
                if (r_count == MAX_COUNT) begin
                    w_err_next = 1'b1;
                end else begin
                    w_digits_next  = {r_digits[NDIG*4-5:0], w_value};
                    w_count_next   = r_count + CNW'(1);
                    w_key_evt_next = 1'b1;
                end
            end else begin
                w_digits_next[int'(r_cursor)*4 +: 4] = w_value;
                w_key_evt_next = 1'b1;
                if (AUTO_ADV != 0) begin
                    w_cursor_next = cursorInc(r_cursor);
                end
            end
        end else if (!r_mode_q && (w_left_rise != w_right_rise)) begin
            w_cursor_next = w_left_rise ? cursorInc(r_cursor) : cursorDec(r_cursor);
        end

        w_full_next   = (w_count_next == MAX_COUNT);
        w_flt_pt_next = mode ? '0 : ({{(NDIG-1){1'b0}}, 1'b1} << w_cursor_next);
    end

    // Register edge history every cycle so held keys produce a single event
    always_ff @(posedge CLK) begin
        r_pb_q    <= pb;
        r_left_q  <= cur_left;
        r_right_q <= cur_right;
        r_bksp_q  <= bksp;
        r_clr_q   <= clr;
        r_mode_q  <= mode;
    end

    // Register state and outputs; reset overrides any pending action
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_digits  <= '0;
            r_cursor  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_key_evt <= 1'b0;
            r_err     <= 1'b0;
            r_flt_pt  <= {{(NDIG-1){1'b0}}, 1'b1};
        end else begin
            r_digits  <= w_digits_next;
            r_cursor  <= w_cursor_next;
            r_count   <= w_count_next;
            r_full    <= w_full_next;
            r_key_evt <= w_key_evt_next;
            r_err     <= w_err_next;
            r_flt_pt  <= w_flt_pt_next;
        end
    end

    assign digits  = r_digits;
    assign flt_pt  = r_flt_pt;
    assign cursor  = r_cursor;
    assign count   = r_count;
    assign full    = r_full;
    assign key_evt = r_key_evt;
    assign err     = r_err;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed testbench for keypad_entry: a wrapping instance and a saturating
// instance share the same stimulus; expected values are hand-computed.
module tb_keypad_entry;

    logic        clock;
    logic        nrst;
    logic [15:0] pbIn;
    logic        curLeft;
    logic        curRight;
    logic        bkspIn;
    logic        clrIn;
    logic        modeLvl;

    logic [31:0] digitsW, digitsS;
    logic [7:0]  fltPtW, fltPtS;
    logic [2:0]  cursorW, cursorS;
    logic [3:0]  countW, countS;
    logic        fullW, fullS;
    logic        keyEvtW, keyEvtS;
    logic        errW, errS;

    int nAsserts;
    int nFail;

    keypad_entry #(.NDIG(8), .AUTO_ADV(1), .WRAP(1)) dutWrap (
        .CLK(clock), .NRST(nrst), .pb(pbIn), .cur_left(curLeft), .cur_right(curRight),
        .bksp(bkspIn), .clr(clrIn), .mode(modeLvl), .digits(digitsW), .flt_pt(fltPtW),
        .cursor(cursorW), .count(countW), .full(fullW), .key_evt(keyEvtW), .err(errW)
    );

    keypad_entry #(.NDIG(8), .AUTO_ADV(1), .WRAP(0)) dutSat (
        .CLK(clock), .NRST(nrst), .pb(pbIn), .cur_left(curLeft), .cur_right(curRight),
        .bksp(bkspIn), .clr(clrIn), .mode(modeLvl), .digits(digitsS), .flt_pt(fltPtS),
        .cursor(cursorS), .count(countS), .full(fullS), .key_evt(keyEvtS), .err(errS)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic applyStimulus(input logic [15:0] pbV, input logic l, input logic r,
                                 input logic b, input logic c);
        pbIn     = pbV;
        curLeft  = l;
        curRight = r;
        bkspIn   = b;
        clrIn    = c;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pressKey(input int k);
        applyStimulus(16'(32'd1 << k), 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence
    initial begin
        nAsserts = 0;
        nFail    = 0;
        nrst     = 1'b0;
        modeLvl  = 1'b0;
        pbIn     = 16'h0008;
        curLeft  = 1'b0;
        curRight = 1'b0;
        bkspIn   = 1'b0;
        clrIn    = 1'b0;

        // Reset with key 3 held
        applyStimulus(16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_digits", digitsW, 32'h0);
        checkOutput("rst_cursor", cursorW, 3'd0);
        checkOutput("rst_fltpt", fltPtW, 8'h01);
        checkOutput("rst_count", countW, 4'd0);
        checkOutput("rst_full", fullW, 1'b0);
        checkOutput("rst_evt", keyEvtW, 1'b0);
        checkOutput("rst_err", errW, 1'b0);

        // Release reset with key 3 still held: no event
        nrst = 1'b1;
        applyStimulus(16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("held_evt", keyEvtW, 1'b0);
        checkOutput("held_digits", digitsW, 32'h0);

        // Re-press key 3
        idle();
        applyStimulus(16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("k3_digits", digitsW, 32'h3);
        checkOutput("k3_cursor", cursorW, 3'd1);
        checkOutput("k3_fltpt", fltPtW, 8'h02);
        checkOutput("k3_evt", keyEvtW, 1'b1);
        idle();
        checkOutput("k3_evt_off", keyEvtW, 1'b0);

        // Clear, then keys 1..9 in overwrite mode
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_digits", digitsW, 32'h0);
        checkOutput("clr_cursor", cursorW, 3'd0);
        idle();
        for (int k = 1; k <= 9; k++) pressKey(k);
        checkOutput("seq_digits_wrap", digitsW, 32'h8765_4329);
        checkOutput("seq_cursor_wrap", cursorW, 3'd1);
        checkOutput("seq_digits_sat", digitsS, 32'h9765_4321);
        checkOutput("seq_cursor_sat", cursorS, 3'd7);

        // Cursor limits
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("right_at0_sat", cursorS, 3'd0);
        checkOutput("right_at0_wrap", cursorW, 3'd7);
        checkOutput("right_fltpt_wrap", fltPtW, 8'h80);
        idle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
            idle();
        end
        checkOutput("left10_sat", cursorS, 3'd7);
        checkOutput("left10_wrap", cursorW, 3'd1);
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("both_sat", cursorS, 3'd7);
        checkOutput("both_wrap", cursorW, 3'd1);
        checkOutput("both_err", errW, 1'b0);
        idle();

        // Multi-key rejection and press while another key is held
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        pressKey(7);
        applyStimulus(16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("multi_err", errW, 1'b1);
        checkOutput("multi_evt", keyEvtW, 1'b0);
        checkOutput("multi_digits", digitsW, 32'h7);
        checkOutput("multi_cursor", cursorW, 3'd1);
        idle();
        checkOutput("multi_err_off", errW, 1'b0);
        applyStimulus(16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h0024, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("held2_evt", keyEvtW, 1'b1);
        checkOutput("held2_digits", digitsW, 32'h527);
        checkOutput("held2_cursor", cursorW, 3'd3);
        idle();

        // Clear and digit rising together: clear wins
        applyStimulus(16'h0040, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clrdig_digits", digitsW, 32'h0);
        checkOutput("clrdig_evt", keyEvtW, 1'b0);
        idle();

        // Overwrite backspace
        pressKey(9);
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("ow_bksp_digits", digitsW, 32'h0);
        checkOutput("ow_bksp_cursor", cursorW, 3'd0);
        idle();

        // Mode change with digits nonzero
        pressKey(1);
        modeLvl = 1'b1;
        idle();
        checkOutput("mode1_digits", digitsW, 32'h0);
        checkOutput("mode1_fltpt", fltPtW, 8'h00);
        checkOutput("mode1_cursor", cursorW, 3'd0);
        checkOutput("mode1_count", countW, 4'd0);

        // Shift-in entry, backspace and fill
        pressKey(10);
        pressKey(11);
        pressKey(12);
        checkOutput("shift_abc", digitsW, 32'h0000_0ABC);
        checkOutput("shift_cnt3", countW, 4'd3);
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("shift_bksp", digitsW, 32'h0000_00AB);
        checkOutput("shift_cnt2", countW, 4'd2);
        idle();
        for (int k = 1; k <= 6; k++) pressKey(k);
        checkOutput("fill_digits", digitsW, 32'hAB12_3456);
        checkOutput("fill_count", countW, 4'd8);
        checkOutput("fill_full", fullW, 1'b1);
        applyStimulus(16'h0080, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("over_err", errW, 1'b1);
        checkOutput("over_evt", keyEvtW, 1'b0);
        checkOutput("over_digits", digitsW, 32'hAB12_3456);
        idle();
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("shift_left_ign", cursorS, 3'd0);
        checkOutput("shift_fltpt", fltPtS, 8'h00);
        idle();

        // Backspace at count 0 in shift-in mode
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("sclr_full", fullW, 1'b0);
        idle();
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bksp0_count", countW, 4'd0);
        checkOutput("bksp0_err", errW, 1'b0);
        idle();

        // Back to overwrite mode
        pressKey(5);
        checkOutput("shift5_count", countW, 4'd1);
        modeLvl = 1'b0;
        idle();
        checkOutput("mode0_digits", digitsW, 32'h0);
        checkOutput("mode0_fltpt", fltPtW, 8'h01);
        checkOutput("mode0_count", countW, 4'd0);

        // Reset mid-operation overrides pending actions
        pressKey(4);
        nrst = 1'b0;
        applyStimulus(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_digits", digitsW, 32'h0);
        checkOutput("midrst_evt", keyEvtW, 1'b0);
        checkOutput("midrst_cursor", cursorW, 3'd0);
        nrst = 1'b1;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
